// File: rtl/bram_scan_display.sv
// bram_scan_display
//   Fills an external dual-port BRAM through port A with the pattern
//   exp(a) = a ^ SEED, then reads every word back through port B. Each word
//   is compared with exp(a) and shown on NUM_DIGITS active-low hex digits
//   for DWELL cycles. The first mismatch stops the run in ERROR and records
//   its address.
//
//   Optional build macro HEX_BLANK_EN: blank leading zero digits. Digit 0
//   always stays lit.
//
// Ports
//   clk, reset      : clock and synchronous active-high reset
//   start           : begins a run from IDLE, DONE or ERROR
//   busy/done/error : run status
//   err_addr        : address of the first mismatching word
//   addr_a/data_a/we_a : BRAM port A (write only)
//   addr_b/q_b      : BRAM port B (read only, q_b valid 1 cycle after addr_b)
//   seg             : 7 segments per digit, gfedcba, active-low;
//                     digit i = seg[7i+6:7i]
module bram_scan_display #(
    parameter int                DATA_W     = 48,
    parameter int                ADDR_W     = 10,
    parameter int                DEPTH      = 1024,
    parameter int                NUM_DIGITS = 4,
    parameter int                DWELL      = 50000000,
    parameter logic [DATA_W-1:0] SEED       = DATA_W'(48'h0000_A5A5_A5A5)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [ADDR_W-1:0]       err_addr,
    output logic [ADDR_W-1:0]       addr_a,
    output logic [DATA_W-1:0]       data_a,
    output logic                    we_a,
    output logic [ADDR_W-1:0]       addr_b,
    input  logic [DATA_W-1:0]       q_b,
    output logic [7*NUM_DIGITS-1:0] seg
);

    localparam int NIB_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(DWELL - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_RD, S_CMP, S_SHOW, S_DONE, S_ERROR
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_W-1:0]       addr;
    logic [CNT_W-1:0]        cnt;
    logic [NIB_W-1:0]        disp_word;
    logic                    disp_vld;
    logic [7*NUM_DIGITS-1:0] seg_nxt;
    logic                    lit;
    logic                    word_bad;

    function automatic logic [DATA_W-1:0] exp_word(input logic [ADDR_W-1:0] a);
        return DATA_W'(a) ^ SEED;
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0011000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b0100111;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign word_bad = (q_b != exp_word(addr));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_FILL;
            S_FILL:  if (addr == LAST_ADDR) state_nxt = S_RD;
            S_RD:    state_nxt = S_CMP;
            S_CMP:   state_nxt = word_bad ? S_ERROR : S_SHOW;
            S_SHOW:  if (cnt == LAST_CNT)
                         state_nxt = (addr == LAST_ADDR) ? S_DONE : S_RD;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address / dwell counters, error capture and display latch
    always_ff @(posedge clk) begin
        if (reset) begin
            addr      <= '0;
            cnt       <= '0;
            err_addr  <= '0;
            disp_word <= '0;
            disp_vld  <= 1'b0;
            seg       <= '1;
        end else begin
            // seg trails the display latch by one cycle
            seg <= disp_vld ? seg_nxt : '1;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        addr     <= '0;
                        err_addr <= '0;
                    end
                end
                S_FILL: addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
                S_CMP: begin
                    disp_word <= q_b[NIB_W-1:0];
                    disp_vld  <= 1'b1;
                    cnt       <= '0;
                    if (word_bad) err_addr <= addr;
                end
                S_SHOW: begin
                    if (cnt == LAST_CNT) begin
                        if (addr != LAST_ADDR) addr <= addr + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Digit decode; with blanking, a digit is lit once any nibble at or
    // above it is non-zero (scanning from the top), and digit 0 always is.
    always_comb begin
        seg_nxt = '1;
        lit     = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
`ifdef HEX_BLANK_EN
            lit = lit | (disp_word[4*i +: 4] != 4'h0) | (i == 0);
`else
            lit = 1'b1;
`endif
            if (lit) seg_nxt[7*i +: 7] = hex7(disp_word[4*i +: 4]);
        end
    end

    assign busy   = (state == S_FILL) || (state == S_RD) ||
                    (state == S_CMP)  || (state == S_SHOW);
    assign done   = (state == S_DONE);
    assign error  = (state == S_ERROR);
    assign we_a   = (state == S_FILL);
    assign addr_a = we_a ? addr : '0;
    assign data_a = we_a ? exp_word(addr) : '0;
    assign addr_b = addr;

endmodule
